// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and helpers for the next-PC selection unit.
package pc_pkg;

   // Default address width of every PC bus.
   localparam int PC_WIDTH = 32;

   // Default value loaded into the PC register on reset.
   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

   // Encoding of the pc_sel output; 2'b11 is never produced.
   typedef enum logic [1:0] {
      PCSEL_SEQ = 2'b00,
      PCSEL_BR  = 2'b01,
      PCSEL_JMP = 2'b10
   } pc_sel_e;

   // A fetch address is word-aligned only when its two low bits are zero.
   function automatic logic low_bits_misaligned(input logic [1:0] low_bits);
      return (low_bits != 2'b00);
   endfunction

   // Clears the byte offset of a 2-bit address slice.
   function automatic logic [1:0] aligned_low_bits(input logic [1:0] low_bits);
      return low_bits & 2'b00;
   endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: WIDTH-bit load-enable register holding the architectural PC.
// Resets asynchronously to RESET_PC; holds its value while en is low.
module pc_reg
   import pc_pkg::*;
#(
   parameter int               WIDTH    = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_PC = PC_RESET_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] pc_r;

   // PC storage: async clear to RESET_PC, load on enable, otherwise hold (stall).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= RESET_PC;
      end else if (en) begin
         pc_r <= d;
      end else begin
         pc_r <= pc_r;
      end
   end

   assign q = pc_r;

endmodule

// File: rtl/pc_src.sv
// pc_src: next-PC selection for the single-cycle datapath.
// Chooses jump > branch > sequential target combinationally, flags
// misaligned targets, and keeps the PC register plus a sticky
// misalignment error flag.
module pc_src
   import pc_pkg::*;
#(
   parameter int               WIDTH    = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_PC = PC_RESET_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Branch,
   input  logic             Jump,
   input  logic [WIDTH-1:0] PCPlus4,
   input  logic [WIDTH-1:0] PCBranch,
   input  logic [WIDTH-1:0] JumpAddr,
   input  logic             PCWrite,
   output logic [WIDTH-1:0] next_PC,
   output logic [WIDTH-1:0] PC,
   output logic [1:0]       pc_sel,
   output logic             misalign,
   output logic             misalign_err
);

   pc_sel_e          sel_s;
   logic [WIDTH-1:0] next_pc_s;
   logic [WIDTH-1:0] load_pc_s;
   logic             misalign_s;
   logic             misalign_err_r;
   logic [WIDTH-1:0] pc_q_s;

   // Source priority: a jump overrides a taken branch, which overrides PC+4.
   always_comb begin
      sel_s = PCSEL_SEQ;
      if (Jump) begin
         sel_s = PCSEL_JMP;
      end else if (Branch) begin
         sel_s = PCSEL_BR;
      end else begin
         sel_s = PCSEL_SEQ;
      end
   end

   // Target mux: targets pass through untouched, no arithmetic here.
   always_comb begin
      next_pc_s = PCPlus4;
      case (sel_s)
         PCSEL_SEQ: next_pc_s = PCPlus4;
         PCSEL_BR:  next_pc_s = PCBranch;
         PCSEL_JMP: next_pc_s = JumpAddr;
         default:   next_pc_s = PCPlus4;
      endcase
   end

   // Alignment check and the word-aligned value actually loaded into PC.
   always_comb begin
      misalign_s = low_bits_misaligned(next_pc_s[1:0]);
      load_pc_s  = {next_pc_s[WIDTH-1:2], aligned_low_bits(next_pc_s[1:0])};
   end

   // Sticky error: set when a misaligned target is loaded; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_err_r <= 1'b0;
      end else if (PCWrite && misalign_s) begin
         misalign_err_r <= 1'b1;
      end else begin
         misalign_err_r <= misalign_err_r;
      end
   end

   pc_reg #(
      .WIDTH    (WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (PCWrite),
      .d     (load_pc_s),
      .q     (pc_q_s)
   );

   assign next_PC      = next_pc_s;
   assign pc_sel       = sel_s;
   assign misalign     = misalign_s;
   assign PC           = pc_q_s;
   assign misalign_err = misalign_err_r;

endmodule

// File: tb/tb_pc_src.sv
// tb_pc_src: directed plus randomized checks of pc_src against a
// behavioural next-PC model kept in the bench.
module tb_pc_src;

   logic        clk;
   logic        rst_n;
   logic        Branch;
   logic        Jump;
   logic [31:0] PCPlus4;
   logic [31:0] PCBranch;
   logic [31:0] JumpAddr;
   logic        PCWrite;
   logic [31:0] next_PC;
   logic [31:0] PC;
   logic [1:0]  pc_sel;
   logic        misalign;
   logic        misalign_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: what PC and the sticky flag should hold.
   logic [31:0] exp_pc;
   logic        exp_err;

   pc_src #(
      .WIDTH    (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Branch       (Branch),
      .Jump         (Jump),
      .PCPlus4      (PCPlus4),
      .PCBranch     (PCBranch),
      .JumpAddr     (JumpAddr),
      .PCWrite      (PCWrite),
      .next_PC      (next_PC),
      .PC           (PC),
      .pc_sel       (pc_sel),
      .misalign     (misalign),
      .misalign_err (misalign_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural reference: the chosen address by priority.
   function automatic logic [31:0] ref_next(input logic j, input logic b,
                                            input logic [31:0] p4,
                                            input logic [31:0] pb,
                                            input logic [31:0] ja);
      if (j) return ja;
      if (b) return pb;
      return p4;
   endfunction

   function automatic logic [31:0] ref_sel(input logic j, input logic b);
      if (j) return 32'd2;
      if (b) return 32'd1;
      return 32'd0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Check the combinational outputs against the model for the current inputs.
   task automatic check_comb(input string tag);
      logic [31:0] e;
      e = ref_next(Jump, Branch, PCPlus4, PCBranch, JumpAddr);
      check({tag, "_next"}, next_PC, e);
      check({tag, "_sel"}, {30'd0, pc_sel}, ref_sel(Jump, Branch));
      check({tag, "_mis"}, {31'd0, misalign}, {31'd0, (e % 32'd4) != 32'd0});
   endtask

   // One clock: update the model across the edge, then check PC and the flag.
   task automatic clock_and_check(input string tag);
      logic [31:0] e;
      e = ref_next(Jump, Branch, PCPlus4, PCBranch, JumpAddr);
      @(posedge clk);
      if (rst_n && PCWrite) begin
         exp_pc = (e / 32'd4) * 32'd4;
         if ((e % 32'd4) != 32'd0) exp_err = 1'b1;
      end
      #1;
      check({tag, "_pc"}, PC, exp_pc);
      check({tag, "_err"}, {31'd0, misalign_err}, {31'd0, exp_err});
   endtask

   task automatic set_in(input logic b, input logic j, input logic w);
      Branch  = b;
      Jump    = j;
      PCWrite = w;
      #1;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom();
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      return a;
   endfunction

   initial begin
      logic [31:0] held;
      rst_n    = 1'b0;
      Branch   = 1'b0;
      Jump     = 1'b0;
      PCWrite  = 1'b1;
      PCPlus4  = 32'h0000_0004;
      PCBranch = 32'h0000_1000;
      JumpAddr = 32'h0000_2000;
      exp_pc   = 32'h0000_0000;
      exp_err  = 1'b0;
      #1;
      check("rst_pc", PC, 32'h0000_0000);
      check("rst_err", {31'd0, misalign_err}, 32'd0);
      check_comb("rst_comb");
      set_in(1'b1, 1'b0, 1'b1);
      check_comb("rst_comb_br");

      // Release reset between edges.
      @(negedge clk);
      rst_n = 1'b1;
      set_in(1'b0, 1'b0, 1'b1);
      check("seq_next", next_PC, 32'h0000_0004);
      check("seq_sel", {30'd0, pc_sel}, 32'd0);
      clock_and_check("seq");
      check("seq_pc_abs", PC, 32'h0000_0004);

      set_in(1'b1, 1'b0, 1'b1);
      check("br_next", next_PC, 32'h0000_1000);
      check("br_sel", {30'd0, pc_sel}, 32'd1);
      clock_and_check("br");
      check("br_pc_abs", PC, 32'h0000_1000);

      set_in(1'b0, 1'b1, 1'b1);
      check("jmp_next", next_PC, 32'h0000_2000);
      check("jmp_sel", {30'd0, pc_sel}, 32'd2);
      clock_and_check("jmp");
      check("jmp_pc_abs", PC, 32'h0000_2000);

      set_in(1'b1, 1'b1, 1'b1);
      check("both_next", next_PC, 32'h0000_2000);
      check("both_sel", {30'd0, pc_sel}, 32'd2);
      clock_and_check("both");

      // Stall for three cycles while the inputs move.
      held = PC;
      for (int i = 0; i < 3; i++) begin
         PCPlus4  = rand_addr();
         PCBranch = rand_addr();
         JumpAddr = rand_addr();
         set_in(1'(i == 1), 1'(i == 2), 1'b0);
         check_comb("stall_comb");
         clock_and_check("stall");
         check("stall_hold", PC, held);
      end

      // Misaligned jump target during a stall: no load and no flag.
      PCPlus4  = 32'h0000_0004;
      PCBranch = 32'h0000_1000;
      JumpAddr = 32'h0000_2002;
      set_in(1'b0, 1'b1, 1'b0);
      check("mis_stall_m", {31'd0, misalign}, 32'd1);
      clock_and_check("mis_stall");
      check("mis_stall_err", {31'd0, misalign_err}, 32'd0);

      // Misaligned jump target loaded: PC is aligned, flag becomes sticky.
      set_in(1'b0, 1'b1, 1'b1);
      check("mis_m", {31'd0, misalign}, 32'd1);
      clock_and_check("mis");
      check("mis_pc_abs", PC, 32'h0000_2000);
      check("mis_err_abs", {31'd0, misalign_err}, 32'd1);
      set_in(1'b0, 1'b0, 1'b1);
      clock_and_check("mis_sticky");

      // Reset between edges clears immediately.
      rst_n = 1'b0;
      #1;
      exp_pc  = 32'h0000_0000;
      exp_err = 1'b0;
      check("mid_rst_pc", PC, 32'h0000_0000);
      check("mid_rst_err", {31'd0, misalign_err}, 32'd0);
      check_comb("mid_rst_comb");
      clock_and_check("rst_held");
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic against the model, with one reset in the middle.
      for (int i = 0; i < 300; i++) begin
         PCPlus4  = rand_addr();
         PCBranch = rand_addr();
         JumpAddr = rand_addr();
         set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0));
         check_comb("rnd_comb");
         clock_and_check("rnd");
         if (i == 150) begin
            rst_n = 1'b0;
            #1;
            exp_pc  = 32'h0000_0000;
            exp_err = 1'b0;
            check("rnd_rst_pc", PC, exp_pc);
            check("rnd_rst_err", {31'd0, misalign_err}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
